// File: rtl/sd_drive_arbiter.sv
// Round-robin arbiter that multiplexes DRIVES floppy-controller clients onto one
// HPS disk-image channel, with a shared sector buffer, mount tracking and an ack timeout.
module sd_drive_arbiter #(
  parameter int DRIVES       = 2,
  parameter int SECTOR_BYTES = 512,
  parameter int TIMEOUT      = 16_000_000,
  localparam int AW          = $clog2(SECTOR_BYTES)
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [DRIVES-1:0]    img_mounted,
  input  logic [63:0]          img_size,
  input  logic [DRIVES-1:0]    cl_rd,
  input  logic [DRIVES-1:0]    cl_wr,
  input  logic [32*DRIVES-1:0] cl_lba,
  output logic [DRIVES-1:0]    cl_busy,
  output logic [DRIVES-1:0]    cl_done,
  output logic [DRIVES-1:0]    cl_err,
  input  logic [AW-1:0]        cl_buf_addr,
  input  logic [7:0]           cl_buf_din,
  input  logic                 cl_buf_we,
  output logic [7:0]           cl_buf_dout,
  output logic [31:0]          sd_lba,
  output logic [DRIVES-1:0]    sd_rd,
  output logic [DRIVES-1:0]    sd_wr,
  input  logic                 sd_ack,
  input  logic [AW-1:0]        sd_buff_addr,
  input  logic [7:0]           sd_buff_dout,
  output logic [7:0]           sd_buff_din,
  input  logic                 sd_buff_wr
);

  localparam int PW = (DRIVES > 1) ? $clog2(DRIVES) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_XFER     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]        state;
  logic [DRIVES-1:0] pend;
  logic [DRIVES-1:0] dir;      // 1 = write to host image
  logic [DRIVES-1:0] bad;
  logic [DRIVES-1:0] mounted;
  logic [31:0]       lba [DRIVES];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     cur;
  logic [DRIVES-1:0] cur_oh;
  logic              err_r;
  logic [CW-1:0]     to_cnt;

  logic              sel_valid;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     cand;

  assign cl_busy = pend;
  assign cur_oh  = DRIVES'(1) << cur;

  // Round-robin search starting just after the last slot granted.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel       = ptr;
    cand      = ptr;
    for (int k = 1; k <= DRIVES; k++) begin
      cand = PW'((int'(ptr) + k) % DRIVES);
      if (!sel_valid && pend[cand]) begin
        sel_valid = 1'b1;
        sel       = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the values from before the clock edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      ptr     <= PW'(DRIVES - 1);
      cur     <= '0;
      pend    <= '0;
      dir     <= '0;
      bad     <= '0;
      mounted <= '0;
      for (int i = 0; i < DRIVES; i++) lba[i] <= '0;
      err_r   <= 1'b0;
      to_cnt  <= '0;
      sd_lba  <= '0;
      sd_rd   <= '0;
      sd_wr   <= '0;
      cl_done <= '0;
      cl_err  <= '0;
    end else begin
      cl_done <= '0;

      for (int i = 0; i < DRIVES; i++) begin
        if (img_mounted[i]) mounted[i] <= (img_size != 64'd0);
        // A pulse on a slot that already holds a request is dropped.
        if ((cl_rd[i] || cl_wr[i]) && !pend[i]) begin
          pend[i] <= 1'b1;
          dir[i]  <= cl_wr[i];
          bad[i]  <= cl_rd[i] && cl_wr[i];
          lba[i]  <= cl_lba[32*i +: 32];
        end
      end

      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            ptr <= sel;
            cur <= sel;
            if (bad[sel] || !mounted[sel]) begin
              err_r <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          sd_lba <= lba[cur];
          sd_rd  <= dir[cur] ? '0 : cur_oh;
          sd_wr  <= dir[cur] ? cur_oh : '0;
          to_cnt <= '0;
          state  <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (sd_ack) begin
            sd_rd <= '0;
            sd_wr <= '0;
            state <= S_XFER;
          end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
            sd_rd <= '0;
            sd_wr <= '0;
            err_r <= 1'b1;
            state <= S_DONE;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        S_XFER: begin
          if (!sd_ack) begin
            err_r <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          cl_done     <= cur_oh;
          cl_err[cur] <= err_r;
          pend[cur]   <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Host and client writes never overlap in time, so one write port suffices.
  logic [7:0]    mem [SECTOR_BYTES];
  logic          host_we;
  logic          client_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  assign host_we   = sd_buff_wr && (state == S_XFER);
  assign client_we = cl_buf_we && !(state inside {S_ISSUE, S_WAIT_ACK, S_XFER});
  assign mem_waddr = host_we ? sd_buff_addr : cl_buf_addr;
  assign mem_wdata = host_we ? sd_buff_dout : cl_buf_din;

  // NOTE: the RAM array has no reset so it maps onto block RAM.
  always_ff @(posedge clk_sys) begin
    if (host_we || client_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cl_buf_dout <= '0;
      sd_buff_din <= '0;
    end else begin
      cl_buf_dout <= mem[cl_buf_addr];
      sd_buff_din <= mem[sd_buff_addr];
    end
  end

endmodule
